a2d_arb: RTL and testbench

//  Shares the single A2D converter between two requesters: port 0 is motion_cntrl (IR sensor reads)
//  and port 1 is a secondary monitor such as battery or aux channels. Each requester keeps its

---
 rtl/a2d_arb_if.sv | 32 +++
 rtl/a2d_arb.sv | 120 ++++++++++++
 tb/tb_a2d_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_arb_if.sv
// Handshake bundle between the two A2D requesters, the shared converter and the arbiter.
interface a2d_arb_if #(
    parameter int RES_W = 12
);
    logic             req0_strt;
    logic [2:0]       req0_chnnl;
    logic             req0_cmplt;
    logic [RES_W-1:0] req0_res;
    logic             req1_strt;
    logic [2:0]       req1_chnnl;
    logic             req1_cmplt;
    logic [RES_W-1:0] req1_res;
    logic             a2d_strt_cnv;
    logic [2:0]       a2d_chnnl;
    logic             a2d_cnv_cmplt;
    logic [RES_W-1:0] a2d_res;
    logic             busy;
    logic             req_ovr;
    logic             timeout_err;

    modport slave (
        input  req0_strt, req0_chnnl, req1_strt, req1_chnnl, a2d_cnv_cmplt, a2d_res,
        output req0_cmplt, req0_res, req1_cmplt, req1_res, a2d_strt_cnv, a2d_chnnl,
               busy, req_ovr, timeout_err
    );

    modport master (
        output req0_strt, req0_chnnl, req1_strt, req1_chnnl, a2d_cnv_cmplt, a2d_res,
        input  req0_cmplt, req0_res, req1_cmplt, req1_res, a2d_strt_cnv, a2d_chnnl,
               busy, req_ovr, timeout_err
    );
endinterface

// File: rtl/a2d_arb.sv
// Round-robin arbiter sharing one A2D converter between two requesters, with a
// per-conversion watchdog that returns a zero result instead of hanging the owner.
module a2d_arb #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int RES_W       = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    a2d_arb_if.slave bus
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, CNV, WAIT} state_t;

    state_t           state;
    logic             pend0;
    logic             pend1;
    logic             owner;
    logic             last_gnt;
    logic [2:0]       ch0;
    logic [2:0]       ch1;
    logic [WD_W-1:0]  wdog;
    logic             own0;
    logic             own1;
    logic             acc0;
    logic             acc1;
    logic             ovr_hit;
    logic             gnt;
    logic             done;
    logic [RES_W-1:0] done_res;

    always_comb begin
        own0     = (state != IDLE) && !owner;
        own1     = (state != IDLE) && owner;
        acc0     = bus.req0_strt && !pend0 && !own0;
        acc1     = bus.req1_strt && !pend1 && !own1;
        ovr_hit  = (bus.req0_strt && !acc0) || (bus.req1_strt && !acc1);
        // On contention the port that did not win last time goes first
        gnt      = (pend0 && pend1) ? !last_gnt : pend1;
        done     = bus.a2d_cnv_cmplt || (wdog == WD_LAST);
        done_res = bus.a2d_cnv_cmplt ? bus.a2d_res : RES_W'(0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pend0            <= 1'b0;
            pend1            <= 1'b0;
            owner            <= 1'b0;
            last_gnt         <= 1'b1;
            ch0              <= '0;
            ch1              <= '0;
            wdog             <= '0;
            bus.req0_cmplt   <= 1'b0;
            bus.req0_res     <= '0;
            bus.req1_cmplt   <= 1'b0;
            bus.req1_res     <= '0;
            bus.a2d_strt_cnv <= 1'b0;
            bus.a2d_chnnl    <= '0;
            bus.busy         <= 1'b0;
            bus.req_ovr      <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.a2d_strt_cnv <= 1'b0;
            bus.req0_cmplt   <= 1'b0;
            bus.req1_cmplt   <= 1'b0;
            if (acc0) begin
                pend0 <= 1'b1;
                ch0   <= bus.req0_chnnl;
            end
            if (acc1) begin
                pend1 <= 1'b1;
                ch1   <= bus.req1_chnnl;
            end
            if (ovr_hit) bus.req_ovr <= 1'b1;

            case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        owner    <= gnt;
                        last_gnt <= gnt;
                        if (gnt) begin
                            pend1         <= 1'b0;
                            bus.a2d_chnnl <= ch1;
                        end else begin
                            pend0         <= 1'b0;
                            bus.a2d_chnnl <= ch0;
                        end
                        bus.a2d_strt_cnv <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= CNV;
                    end
                end
                CNV: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A real completion wins over a watchdog expiry in the same cycle
                    if (done) begin
                        if (owner) begin
                            bus.req1_res   <= done_res;
                            bus.req1_cmplt <= 1'b1;
                        end else begin
                            bus.req0_res   <= done_res;
                            bus.req0_cmplt <= 1'b1;
                        end
                        if (!bus.a2d_cnv_cmplt) bus.timeout_err <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_arb.sv
// Bench for a2d_arb: timestamp-based reference model, converter model and requester stimulus.
module tb_a2d_arb;
    localparam int TO = 32;
    localparam int RW = 12;

    typedef struct {
        int c;
        int v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a2d_arb_if #(.RES_W(RW)) bus ();
    a2d_arb #(.TIMEOUT_CYC(TO), .RES_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [RW-1:0] res_tab [8] = '{12'h123, 12'h0F7, 12'h3C1, 12'h6E2,
                                   12'hA5C, 12'h2B9, 12'hD04, 12'h7FE};

    int total = 0;
    int bad = 0;

    // Reference model: tracks pending requests and the in-flight conversion by cycle stamps
    int            cyc = 0;
    bit            m_pend [2];
    logic [2:0]    m_ch [2];
    bit            m_last;
    bit            m_infl;
    bit            m_own;
    int            m_strt_c;
    logic [2:0]    e_chnnl;
    logic [RW-1:0] e_res [2];
    int            e_cmp_c [2];
    bit            e_ovr;
    bit            e_tmo;
    int            n_acc [2] = '{0, 0};
    bit            op [2];
    bit            s_strt;
    logic [2:0]    s_ch;
    bit            g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend[0] = 0; m_pend[1] = 0; m_ch[0] = 0; m_ch[1] = 0;
            m_last = 1; m_infl = 0; m_own = 0; m_strt_c = -1;
            e_chnnl = 0; e_res[0] = 0; e_res[1] = 0;
            e_cmp_c[0] = -1; e_cmp_c[1] = -1; e_ovr = 0; e_tmo = 0;
        end else begin
            op[0] = m_pend[0];
            op[1] = m_pend[1];
            for (int k = 0; k < 2; k++) begin
                s_strt = (k == 0) ? bus.req0_strt : bus.req1_strt;
                s_ch   = (k == 0) ? bus.req0_chnnl : bus.req1_chnnl;
                if (s_strt) begin
                    if (m_pend[k] || (m_infl && int'(m_own) == k)) e_ovr = 1;
                    else begin
                        m_pend[k] = 1;
                        m_ch[k]   = s_ch;
                        n_acc[k]++;
                    end
                end
            end
            if (m_infl) begin
                if (cyc > m_strt_c && bus.a2d_cnv_cmplt) begin
                    e_res[m_own] = bus.a2d_res; e_cmp_c[m_own] = cyc + 1; m_infl = 0;
                end else if (cyc - m_strt_c == TO) begin
                    e_res[m_own] = 0; e_cmp_c[m_own] = cyc + 1; m_infl = 0; e_tmo = 1;
                end
            end else if (op[0] || op[1]) begin
                g = (op[0] && op[1]) ? !m_last : op[1];
                m_pend[g] = 0; m_last = g; m_own = g; m_infl = 1;
                m_strt_c = cyc + 1; e_chnnl = m_ch[g];
            end
            cyc++;
        end
    end

    // Converter model and event logs
    ev_t        strt_q[$];
    ev_t        cq0[$];
    ev_t        cq1[$];
    int         dut_cmp [2] = '{0, 0};
    int         cnv_cnt = 0;
    logic [2:0] cnv_ch = 0;
    bit         cnv_hang = 0;
    int         dly_min = 1;
    int         dly_max = 12;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        strt_q.delete();
        cq0.delete();
        cq1.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.a2d_strt_cnv === 1'b1) begin
            strt_q.push_back('{cyc, int'(bus.a2d_chnnl)});
            if (!cnv_hang) begin
                cnv_cnt = $urandom_range(dly_max, dly_min);
                cnv_ch  = bus.a2d_chnnl;
            end
        end
        if (bus.req0_cmplt === 1'b1) begin
            cq0.push_back('{cyc, int'(bus.req0_res)});
            dut_cmp[0]++;
        end
        if (bus.req1_cmplt === 1'b1) begin
            cq1.push_back('{cyc, int'(bus.req1_res)});
            dut_cmp[1]++;
        end
        check("strt_cnv", 32'(bus.a2d_strt_cnv), 32'(m_infl && cyc == m_strt_c));
        check("a2d_chnnl", 32'(bus.a2d_chnnl), 32'(e_chnnl));
        check("busy", 32'(bus.busy), 32'(m_infl));
        check("req0_cmplt", 32'(bus.req0_cmplt), 32'(cyc == e_cmp_c[0]));
        check("req0_res", 32'(bus.req0_res), 32'(e_res[0]));
        check("req1_cmplt", 32'(bus.req1_cmplt), 32'(cyc == e_cmp_c[1]));
        check("req1_res", 32'(bus.req1_res), 32'(e_res[1]));
        check("req_ovr", 32'(bus.req_ovr), 32'(e_ovr));
        check("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
        @(posedge clk);
        #1;
        bus.req0_strt     = 1'b0;
        bus.req1_strt     = 1'b0;
        bus.a2d_cnv_cmplt = 1'b0;
        bus.a2d_res       = RW'($urandom);
        if (!rst_n) cnv_cnt = 0;
        else if (cnv_cnt > 0) begin
            cnv_cnt--;
            if (cnv_cnt == 0) begin
                bus.a2d_cnv_cmplt = 1'b1;
                bus.a2d_res       = res_tab[cnv_ch];
            end
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while ((m_infl || m_pend[0] || m_pend[1] || cyc <= e_cmp_c[0] || cyc <= e_cmp_c[1])
               && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    int  t0;
    int  n;
    int  a0, a1, d0, d1;
    bit  p0_busy;
    int  gap;
    logic [2:0] ir_ch;

    initial begin
        bus.req0_strt = 0; bus.req0_chnnl = 0; bus.req1_strt = 0; bus.req1_chnnl = 0;
        bus.a2d_cnv_cmplt = 0; bus.a2d_res = 0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strt", 32'(bus.a2d_strt_cnv), 32'd0);
        check("rst_res0", 32'(bus.req0_res), 32'd0);
        check("rst_ovr", 32'(bus.req_ovr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request, 30-cycle conversion
        clear_logs();
        dly_min = 30; dly_max = 30;
        t0 = cyc;
        bus.req0_strt = 1; bus.req0_chnnl = 4;
        tick();
        wait_quiet("t1", 100);
        check("t1_nstrt", 32'(strt_q.size()), 32'd1);
        if (strt_q.size() >= 1) begin
            check("t1_strt_cyc", 32'(strt_q[0].c), 32'(t0 + 2));
            check("t1_chnnl", 32'(strt_q[0].v), 32'd4);
        end
        check("t1_ncmp0", 32'(cq0.size()), 32'd1);
        if (cq0.size() >= 1) begin
            check("t1_cmp_cyc", 32'(cq0[0].c), 32'(t0 + 33));
            check("t1_res", 32'(cq0[0].v), 32'hA5C);
        end
        check("t1_ncmp1", 32'(cq1.size()), 32'd0);
        check("t1_res1", 32'(bus.req1_res), 32'd0);

        // Contention after reset: port 0 first
        do_reset();
        dly_min = 5; dly_max = 10;
        t0 = cyc;
        bus.req0_strt = 1; bus.req0_chnnl = 1; bus.req1_strt = 1; bus.req1_chnnl = 6;
        tick();
        wait_quiet("t2a", 100);
        check("t2a_nstrt", 32'(strt_q.size()), 32'd2);
        if (strt_q.size() >= 2) begin
            check("t2a_first", 32'(strt_q[0].v), 32'd1);
            check("t2a_first_cyc", 32'(strt_q[0].c), 32'(t0 + 2));
            check("t2a_second", 32'(strt_q[1].v), 32'd6);
        end
        if (cq0.size() >= 1) check("t2a_res0", 32'(cq0[0].v), 32'h0F7);
        if (cq1.size() >= 1) check("t2a_res1", 32'(cq1[0].v), 32'hD04);
        // A lone port-0 conversion makes port 0 the last winner
        bus.req0_strt = 1; bus.req0_chnnl = 3;
        tick();
        wait_quiet("t2b", 100);
        clear_logs();
        bus.req0_strt = 1; bus.req0_chnnl = 2; bus.req1_strt = 1; bus.req1_chnnl = 5;
        tick();
        wait_quiet("t2c", 100);
        check("t2c_nstrt", 32'(strt_q.size()), 32'd2);
        if (strt_q.size() >= 2 && cq1.size() >= 1) begin
            check("t2c_first", 32'(strt_q[0].v), 32'd5);
            check("t2c_second", 32'(strt_q[1].v), 32'd2);
            check("t2c_b2b", 32'(strt_q[1].c), 32'(cq1[0].c + 1));
        end

        // Overrun while in flight
        clear_logs();
        dly_min = 10; dly_max = 10;
        check("t3_ovr_before", 32'(bus.req_ovr), 32'd0);
        bus.req1_strt = 1; bus.req1_chnnl = 3;
        repeat (4) tick();
        bus.req1_strt = 1; bus.req1_chnnl = 6;
        tick();
        wait_quiet("t3", 100);
        check("t3_nstrt", 32'(strt_q.size()), 32'd1);
        check("t3_ncmp1", 32'(cq1.size()), 32'd1);
        check("t3_ovr", 32'(bus.req_ovr), 32'd1);
        if (cq1.size() >= 1) check("t3_res", 32'(cq1[0].v), 32'h6E2);

        // Watchdog expiry, then the queued port-1 request runs normally
        clear_logs();
        cnv_hang = 1;
        bus.req0_strt = 1; bus.req0_chnnl = 2;
        repeat (4) tick();
        bus.req1_strt = 1; bus.req1_chnnl = 5;
        tick();
        n = 0;
        while (cq0.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        check("t4_cmp_seen", 32'(cq0.size()), 32'd1);
        cnv_hang = 0;
        wait_quiet("t4", 100);
        check("t4_nstrt", 32'(strt_q.size()), 32'd2);
        if (strt_q.size() >= 2 && cq0.size() >= 1) begin
            check("t4_tmo_cyc", 32'(cq0[0].c), 32'(strt_q[0].c + 1 + TO));
            check("t4_tmo_res", 32'(cq0[0].v), 32'd0);
            check("t4_next_ch", 32'(strt_q[1].v), 32'd5);
            check("t4_next_cyc", 32'(strt_q[1].c), 32'(cq0[0].c + 1));
        end
        check("t4_tmo_err", 32'(bus.timeout_err), 32'd1);
        if (cq1.size() >= 1) check("t4_res1", 32'(cq1[0].v), 32'h2B9);

        // Reset during WAIT with port 1 pending, then a late converter completion
        do_reset();
        dly_min = 20; dly_max = 20;
        bus.req0_strt = 1; bus.req0_chnnl = 0;
        repeat (5) tick();
        bus.req1_strt = 1; bus.req1_chnnl = 7;
        repeat (3) tick();
        rst_n = 1'b0;
        clear_logs();
        tick();
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_chnnl", 32'(bus.a2d_chnnl), 32'd0);
        check("t5_tmo", 32'(bus.timeout_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.a2d_cnv_cmplt = 1; bus.a2d_res = 12'hFFF;
        repeat (6) tick();
        check("t5_no_cmp0", 32'(cq0.size()), 32'd0);
        check("t5_no_cmp1", 32'(cq1.size()), 32'd0);
        check("t5_no_strt", 32'(strt_q.size()), 32'd0);
        bus.req1_strt = 1; bus.req1_chnnl = 7;
        tick();
        wait_quiet("t5", 100);
        check("t5_ncmp1", 32'(cq1.size()), 32'd1);
        if (cq1.size() >= 1) check("t5_res1", 32'(cq1[0].v), 32'h7FE);

        // Motion controller on port 0 plus random port-1 traffic
        clear_logs();
        dly_min = 1; dly_max = 15;
        a0 = n_acc[0]; a1 = n_acc[1]; d0 = dut_cmp[0]; d1 = dut_cmp[1];
        p0_busy = 0; gap = 0; ir_ch = 0; n = 0;
        while (strt_q.size() < 200 && n < 20000) begin
            if (p0_busy && bus.req0_cmplt) begin
                if ($urandom_range(1, 0) == 1) begin
                    bus.req0_strt = 1; bus.req0_chnnl = ir_ch; ir_ch = ir_ch + 3'd1;
                end else begin
                    p0_busy = 0; gap = $urandom_range(5, 0);
                end
            end else if (!p0_busy) begin
                if (gap > 0) gap--;
                else begin
                    bus.req0_strt = 1; bus.req0_chnnl = ir_ch; ir_ch = ir_ch + 3'd1;
                    p0_busy = 1;
                end
            end
            if ($urandom_range(7, 0) == 0) begin
                bus.req1_strt = 1; bus.req1_chnnl = 3'($urandom_range(7, 0));
            end
            tick();
            n++;
        end
        wait_quiet("t6", 500);
        check("t6_enough", 32'(strt_q.size() >= 200), 32'd1);
        check("t6_one_cmp0", 32'(dut_cmp[0] - d0), 32'(n_acc[0] - a0));
        check("t6_one_cmp1", 32'(dut_cmp[1] - d1), 32'(n_acc[1] - a1));
        check("t6_nconv", 32'(strt_q.size()), 32'((n_acc[0] - a0) + (n_acc[1] - a1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
